// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered WIDTH-bit ALU with valid/ready handshakes, full flags,
//            and an optional iterative shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err
);

    localparam int c_shw    = $clog2(WIDTH);
    localparam bit c_mul_en = (MUL_EN != 0);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;
    localparam logic [3:0] c_op_mul  = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_z, r_n, r_c, r_v, r_err;

    logic             w_accept;
    logic             w_start_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic             w_load;

    logic [c_shw-1:0] w_shamt;
    logic [WIDTH:0]   w_add_full;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_sll, w_srl, w_sra;
    logic             w_slt, w_sltu;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c, w_alu_v, w_alu_err;
    logic [WIDTH-1:0] w_load_res;
    logic             w_load_c, w_load_v, w_load_err;

    // ------------------------------------------------------------------------
    // Handshake and FSM
    // ------------------------------------------------------------------------
    assign in_ready    = (r_state == ST_IDLE) & (~r_out_valid | out_ready);
    assign w_accept    = in_valid & in_ready;
    assign w_start_mul = w_accept & (op == c_op_mul) & c_mul_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_mul) w_state_next = ST_BUSY;
            ST_BUSY: if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    assign w_shamt    = b[c_shw-1:0];
    assign w_add_full = {1'b0, a} + {1'b0, b};
    assign w_sub      = a - b;
    assign w_sll      = a << w_shamt;
    assign w_srl      = a >> w_shamt;
    assign w_sra      = $signed(a) >>> w_shamt;
    assign w_slt      = $signed(a) < $signed(b);
    assign w_sltu     = a < b;

    // MUL lands in the default branch: with the multiplier absent it is
    // illegal, and with it present this path is never loaded for MUL.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_err = 1'b0;
        case (op)
            c_op_add: begin
                w_alu_res = w_add_full[WIDTH-1:0];
                w_alu_c   = w_add_full[WIDTH];
                w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &
                            (w_add_full[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_res = w_sub;
                w_alu_c   = w_sltu;
                w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &
                            (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_and:  w_alu_res = a & b;
            c_op_or:   w_alu_res = a | b;
            c_op_xor:  w_alu_res = a ^ b;
            c_op_sll:  w_alu_res = w_sll;
            c_op_srl:  w_alu_res = w_srl;
            c_op_sra:  w_alu_res = w_sra;
            c_op_slt:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            c_op_sltu: w_alu_res = {{(WIDTH-1){1'b0}}, w_sltu};
            default:   w_alu_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative multiplier: one multiplier bit per BUSY cycle, LSB first
    // ------------------------------------------------------------------------
    generate
        if (c_mul_en) begin : g_mul
            localparam logic [c_shw-1:0] c_cnt_last = c_shw'(WIDTH - 1);

            logic [WIDTH-1:0] r_acc;
            logic [WIDTH-1:0] r_mcand;
            logic [WIDTH-1:0] r_mplier;
            logic [c_shw-1:0] r_cnt;
            logic [WIDTH-1:0] w_sum;

            assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc    <= '0;
                    r_mcand  <= '0;
                    r_mplier <= '0;
                    r_cnt    <= '0;
                end else if (w_start_mul) begin
                    r_acc    <= '0;
                    r_mcand  <= a;
                    r_mplier <= b;
                    r_cnt    <= '0;
                end else if (r_state == ST_BUSY) begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_shw'(1);
                end
            end

            // The last partial product is folded in combinationally so the
            // result is loaded on the WIDTH-th BUSY edge.
            assign w_mul_done    = (r_state == ST_BUSY) & (r_cnt == c_cnt_last);
            assign w_mul_product = w_sum;
        end else begin : g_no_mul
            assign w_mul_done    = 1'b0;
            assign w_mul_product = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    assign w_load     = w_mul_done | (w_accept & ~w_start_mul);
    assign w_load_res = w_mul_done ? w_mul_product : w_alu_res;
    assign w_load_c   = ~w_mul_done & w_alu_c;
    assign w_load_v   = ~w_mul_done & w_alu_v;
    assign w_load_err = ~w_mul_done & w_alu_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_res;
            r_z         <= (w_load_res == '0);
            r_n         <= w_load_res[WIDTH-1];
            r_c         <= w_load_c;
            r_v         <= w_load_v;
            r_err       <= w_load_err;
        end else if (w_accept | (r_out_valid & out_ready)) begin
            // A MUL start also consumes any pending result.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign z         = r_z;
    assign n         = r_n;
    assign c         = r_c;
    assign v         = r_v;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_valid2;
    logic       in_ready, in_ready2;
    logic [7:0] a, b;
    logic [3:0] op;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic [7:0] result, result2;
    logic       z, n, c, v, err;
    logic       z2, n2, c2, v2, err2;
    logic [4:0] fl, fl2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fl  = {z, n, c, v, err};
    assign fl2 = {z2, n2, c2, v2, err2};

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .z(z), .n(n), .c(c), .v(v), .err(err)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid2), .out_ready(1'b1),
        .result(result2), .z(z2), .n(n2), .c(c2), .v(v2), .err(err2)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] fl;   // {z,n,c,v,err}
    } vec_t;

    vec_t vecs [15] = '{
        '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b01010},
        '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b10100},
        '{4'd1,  8'h03, 8'h05, 8'hFE, 5'b01100},
        '{4'd8,  8'hFE, 8'h01, 8'h01, 5'b00000},
        '{4'd9,  8'hFE, 8'h01, 8'h00, 5'b10000},
        '{4'd7,  8'h90, 8'h02, 8'hE4, 5'b01000},
        '{4'd5,  8'h01, 8'h09, 8'h02, 5'b00000},
        '{4'd6,  8'h90, 8'h00, 8'h90, 5'b01000},
        '{4'd6,  8'h90, 8'h03, 8'h12, 5'b00000},
        '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000},
        '{4'd3,  8'hF0, 8'h0F, 8'hFF, 5'b01000},
        '{4'd4,  8'hAA, 8'hAA, 8'h00, 5'b10000},
        '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b00010},
        '{4'd0,  8'h80, 8'h80, 8'h00, 5'b10110},
        '{4'd12, 8'h55, 8'h22, 8'h00, 5'b10001}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        check("issue_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_mul(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic [4:0] ef);
        int cyc;
        int rdy_bad;
        cyc     = 0;
        rdy_bad = 0;
        issue(4'd10, x, y);
        while (!out_valid && cyc < 20) begin
            if (in_ready) rdy_bad++;
            tick();
            cyc++;
        end
        check("mul_latency", cyc, 8);
        check("mul_busy_ready", rdy_bad, 0);
        check("mul_result", result, er);
        check("mul_flags", fl, ef);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", fl, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops, including illegal opcode 12
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), fl, vecs[i].fl);
        end
        tick();
        check("drain_valid", out_valid, 0);

        // Multiplier
        run_mul(8'd13, 8'd11, 8'h8F, 5'b01000);
        run_mul(8'h10, 8'h10, 8'h00, 5'b10000);
        check("mul_drain_valid", out_valid, 0);

        // Reset in the middle of a MUL
        issue(4'd0, 8'h05, 8'h03);
        check("pre_rst_result", result, 8'h08);
        issue(4'd10, 8'd13, 8'd11);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_result", result, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_stale", seen, 0);

        // Backpressure: result held, new offers ignored
        out_ready = 1'b0;
        issue(4'd0, 8'h05, 8'h03);
        op       = 4'd0;
        a        = 8'h20;
        b        = 8'h01;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (result !== 8'h08 || !out_valid || in_ready) bad++;
            tick();
        end
        check("hold_stable", bad, 0);
        check("hold_result", result, 8'h08);

        // Release and stream one op per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'h20 + 8'(i);
            b = 8'(i + 1);
            #1;
            check($sformatf("stream%0d_ready", i), in_ready, 1);
            tick();
            check($sformatf("stream%0d_valid", i), out_valid, 1);
            check($sformatf("stream%0d_result", i), result, 8'h21 + 8'(2 * i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_no_dup", out_valid, 0);

        // MUL_EN=0 build: MUL is illegal with single-cycle latency
        op        = 4'd10;
        a         = 8'h03;
        b         = 8'h05;
        in_valid2 = 1'b1;
        #1;
        check("nomul_ready", in_ready2, 1);
        tick();
        in_valid2 = 1'b0;
        check("nomul_valid", out_valid2, 1);
        check("nomul_result", result2, 0);
        check("nomul_flags", fl2, 5'b10001);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
